// File: rtl/bitstream_decoder.sv
// Stochastic bitstream to binary converter: counts ones over a window of 2^WINDOW_BITS-1 samples
// and presents the unipolar or bipolar result through a valid/ready handshake.
module bitstream_decoder #(
   parameter int unsigned WINDOW_BITS = 4,
   parameter int unsigned BIPOLAR     = 0
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   x,
   input  logic                   start,
   input  logic                   y_ready,
   output logic                   busy,
   output logic                   y_valid,
   output logic [WINDOW_BITS:0]   y
);

   localparam int unsigned            N        = (2 ** WINDOW_BITS) - 1;
   localparam logic [WINDOW_BITS-1:0] LAST_CNT = WINDOW_BITS'(N - 1);
   localparam logic [WINDOW_BITS-1:0] CNT_ONE  = WINDOW_BITS'(1);
   localparam logic [WINDOW_BITS:0]   N_EXT    = (WINDOW_BITS + 1)'(N);

   typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

   state_e                 r_state, w_state_d;
   logic [WINDOW_BITS-1:0] r_ones, w_ones_d;
   logic [WINDOW_BITS-1:0] r_scnt, w_scnt_d;
   logic [WINDOW_BITS-1:0] w_ones_sum;
   logic [WINDOW_BITS:0]   r_y, w_y_d;
   logic [WINDOW_BITS:0]   w_result;
   logic                   r_valid, w_valid_d;

   // At most N ones are ever counted, so the sum cannot wrap.
   assign w_ones_sum = r_ones + {{(WINDOW_BITS - 1){1'b0}}, x};

   always_comb begin
      if (BIPOLAR != 0) begin
         w_result = {w_ones_sum, 1'b0} - N_EXT;
      end else begin
         w_result = {1'b0, w_ones_sum};
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_ones_d  = r_ones;
      w_scnt_d  = r_scnt;
      w_y_d     = r_y;
      w_valid_d = r_valid;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_ones_d  = '0;
               w_scnt_d  = '0;
               w_state_d = StCount;
            end
         end
         StCount: begin
            w_ones_d = w_ones_sum;
            w_scnt_d = r_scnt + CNT_ONE;
            if (r_scnt == LAST_CNT) begin
               w_y_d     = w_result;
               w_valid_d = 1'b1;
               w_state_d = StHold;
            end
         end
         StHold: begin
            if (y_ready) begin
               w_valid_d = 1'b0;
               if (start) begin
                  // Back-to-back window: skip the idle cycle.
                  w_ones_d  = '0;
                  w_scnt_d  = '0;
                  w_state_d = StCount;
               end else begin
                  w_state_d = StIdle;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= StIdle;
         r_ones  <= '0;
         r_scnt  <= '0;
         r_y     <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_ones  <= w_ones_d;
         r_scnt  <= w_scnt_d;
         r_y     <= w_y_d;
         r_valid <= w_valid_d;
      end
   end

   assign busy    = (r_state != StIdle);
   assign y_valid = r_valid;
   assign y       = r_y;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Randomized scoreboard bench: unipolar and bipolar decoders share stimulus; expected ones counts
// are queued by the driver and popped by a monitor whenever a new result appears.
module tb_bitstream_decoder;

   localparam int unsigned WB = 4;
   localparam int          N  = (2 ** WB) - 1;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          x = 1'b0;
   logic          start = 1'b0;
   logic          y_ready = 1'b0;
   logic          busy_u, valid_u, busy_b, valid_b;
   logic [WB:0]   y_u, y_b;

   typedef struct {
      int ones;
      int cyc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_valid = 1'b0;
   logic [WB:0] held_u = '0;
   logic [WB:0] held_b = '0;

   bitstream_decoder #(.WINDOW_BITS(WB), .BIPOLAR(0)) u_uni (
      .clk(clk), .n_rst(n_rst), .x(x), .start(start), .y_ready(y_ready),
      .busy(busy_u), .y_valid(valid_u), .y(y_u)
   );

   bitstream_decoder #(.WINDOW_BITS(WB), .BIPOLAR(1)) u_bi (
      .clk(clk), .n_rst(n_rst), .x(x), .start(start), .y_ready(y_ready),
      .busy(busy_b), .y_valid(valid_b), .y(y_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each new result, checks stability while it is held.
   always @(negedge clk) begin
      if (!n_rst) begin
         prev_valid = 1'b0;
      end else begin
         chk("valid_match", int'(valid_b), int'(valid_u));
         if (valid_u && !prev_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               int   act_b;
               e = q.pop_front();
               act_b = $signed(y_b);
               chk("uni_y", int'(y_u), e.ones);
               chk("bi_y", act_b, 2 * e.ones - N);
               chk("latency", cyc, e.cyc);
               held_u = y_u;
               held_b = y_b;
            end
         end else if (valid_u) begin
            chk("hold_y_uni", int'(y_u), int'(held_u));
            chk("hold_y_bi", int'(y_b), int'(held_b));
            chk("hold_busy", int'(busy_u), 1);
         end
         prev_valid = valid_u;
      end
   end

   // Caller is positioned just after a negedge; returns just after the negedge following edge k+N.
   task automatic run_window(input int kind, input bit mid_start);
      logic bits[N];
      int   ones = 0;
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       bits[i] = 1'b1;
            1:       bits[i] = 1'b0;
            2:       bits[i] = (i % 2 == 0);
            default: bits[i] = 1'($urandom_range(0, 1));
         endcase
         ones += int'(bits[i]);
      end
      q.push_back('{ones: ones, cyc: cyc + 1 + N});
      start = 1'b1;
      x = 1'($urandom_range(0, 1));
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         start   = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
         x       = bits[i];
         y_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
      end
      @(negedge clk);
      start   = 1'b0;
      y_ready = 1'b0;
      x       = 1'($urandom_range(0, 1));
      chk("valid_at_latency", int'(valid_u), 1);
      chk("busy_at_latency", int'(busy_u), 1);
   endtask

   task automatic release_result(input int hold, input bit restart, input int next_kind);
      for (int i = 0; i < hold; i++) begin
         x       = 1'($urandom_range(0, 1));
         start   = 1'($urandom_range(0, 1));
         y_ready = 1'b0;
         @(negedge clk);
      end
      y_ready = 1'b1;
      if (restart) begin
         run_window(next_kind, 1'b0);
      end else begin
         start = 1'b0;
         @(negedge clk);
         y_ready = 1'b0;
         chk("idle_valid", int'(valid_u), 0);
         chk("idle_busy", int'(busy_u), 0);
         chk("idle_busy_bi", int'(busy_b), 0);
         chk("idle_keeps_y", int'(y_u), int'(held_u));
      end
   endtask

   task automatic abort_window();
      start = 1'b1;
      x     = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         start = 1'b0;
         x     = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      chk("abort_busy_before", int'(busy_u), 1);
      n_rst = 1'b0;
      #1;
      chk("abort_busy", int'(busy_u), 0);
      chk("abort_valid", int'(valid_u), 0);
      chk("abort_y", int'(y_u), 0);
      chk("abort_y_bi", int'(y_b), 0);
      held_u = '0;
      held_b = '0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         x       = 1'($urandom_range(0, 1));
         start   = 1'($urandom_range(0, 1));
         y_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("rst_busy", int'(busy_u), 0);
         chk("rst_valid", int'(valid_u), 0);
         chk("rst_y", int'(y_u), 0);
         chk("rst_y_bi", int'(y_b), 0);
      end
      start = 1'b0;
      n_rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         x       = 1'($urandom_range(0, 1));
         y_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("post_rst_busy", int'(busy_u), 0);
         chk("post_rst_valid", int'(valid_u), 0);
         chk("post_rst_y", int'(y_u), 0);
      end
      y_ready = 1'b0;

      run_window(0, 1'b0);
      release_result(0, 1'b0, 0);
      run_window(1, 1'b0);
      release_result(2, 1'b0, 0);
      run_window(2, 1'b1);
      release_result(1, 1'b0, 0);

      // Backpressure then back-to-back all-ones window
      run_window(2, 1'b0);
      release_result(10, 1'b1, 0);
      release_result(3, 1'b0, 0);

      abort_window();
      run_window(0, 1'b0);
      release_result(0, 1'b0, 0);

      for (int w = 0; w < 30; w++) begin
         run_window(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
         while ($urandom_range(0, 2) != 0) begin
            release_result(int'($urandom_range(0, 5)), 1'b1, int'($urandom_range(0, 4)));
         end
         release_result(int'($urandom_range(0, 5)), 1'b0, 0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
